// File: rtl/saph_vga_pkg.sv
// Shared types and constants for the VGA pixel output stage.
//   saph_vga_pixout_state_t : pixel-fetch state (IDLE, RUN, DROP)
//   saph_vga_rgb565_t       : unpacked RGB565 colour payload
//   rgb565_unpack()         : splits a 16-bit pixel word into r/g/b fields
package saph_vga_pkg;

    localparam int unsigned PIX_BITS = 16;

    // RGB565 field positions within a pixel word
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    localparam int unsigned UF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DROP = 2'd2
    } saph_vga_pixout_state_t;

    typedef struct packed {
        logic [R_MSB-R_LSB:0] r;
        logic [G_MSB-G_LSB:0] g;
        logic [B_MSB-B_LSB:0] b;
    } saph_vga_rgb565_t;

    function automatic saph_vga_rgb565_t rgb565_unpack(input logic [PIX_BITS-1:0] w);
        saph_vga_rgb565_t c;
        c.r = w[R_MSB:R_LSB];
        c.g = w[G_MSB:G_LSB];
        c.b = w[B_MSB:B_LSB];
        return c;
    endfunction

endpackage

// File: rtl/saph_vga_pixout_if.sv
// Pixel FIFO handshake between the upstream fetcher and the pixel output stage.
//   pix_data  : pixel word from the FIFO
//   pix_valid : FIFO holds a pixel
//   pix_ready : pixel consumed this cycle
//   flush     : upstream discards FIFO contents and restarts at pixel (0,0)
// master = FIFO side, slave = pixel output stage.
interface saph_vga_pixout_if;
    import saph_vga_pkg::*;

    logic [PIX_BITS-1:0] pix_data;
    logic                pix_valid;
    logic                pix_ready;
    logic                flush;

    modport master (output pix_data, output pix_valid, input pix_ready, input flush);
    modport slave  (input pix_data, input pix_valid, output pix_ready, output flush);

endinterface

// File: rtl/saph_vga_sync_out.sv
// Registered HSYNC/VSYNC/DE with per-signal polarity; updates only on pixel strobes.
//   clk, rst_n            : clock, async active-low reset
//   inc_i                 : pixel strobe
//   h_sync_en_i, v_sync_en_i : timing FSMs in sync region
//   de_i                  : active video
//   hsync_pol_i, vsync_pol_i : 1 = active-high sync
//   hsync_o, vsync_o, de_o   : registered outputs
// Reset drives each sync line to its inactive level for the selected polarity.
module saph_vga_sync_out (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic h_sync_en_i,
    input  logic v_sync_en_i,
    input  logic de_i,
    input  logic hsync_pol_i,
    input  logic vsync_pol_i,
    output logic hsync_o,
    output logic vsync_o,
    output logic de_o
);

    logic hsync_q;
    logic vsync_q;
    logic de_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= ~hsync_pol_i;
            vsync_q <= ~vsync_pol_i;
            de_q    <= 1'b0;
        end else if (inc_i) begin
            hsync_q <= h_sync_en_i ^ ~hsync_pol_i;
            vsync_q <= v_sync_en_i ^ ~vsync_pol_i;
            de_q    <= de_i;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;

endmodule

// File: rtl/saph_vga_pixout.sv
// VGA pixel output stage: registered RGB565 + HSYNC/VSYNC/DE from the timing FSMs,
// pulling pixels from an upstream FIFO and re-aligning on frame boundaries after underflow.
//   clk, rst_n               : VGA core clock, async active-low reset
//   inc                      : pixel strobe
//   h_vid_en/h_sync_en/h_cout: horizontal FSM status
//   v_vid_en/v_sync_en/v_cout: vertical FSM status
//   hsync_pol, vsync_pol     : sync polarity (1 = active-high)
//   border_col               : colour for active pixels without a usable FIFO pixel
//   pix                      : FIFO handshake (slave side; pix_ready is combinational)
//   frame_start              : one-cycle pulse after each frame boundary
//   out_r/out_g/out_b        : registered colour
//   out_hsync/out_vsync/out_de : registered sync and data enable
//   underflow, underflow_clr : sticky underflow flag and its clear
//   uf_count                 : saturating underflow count (only with SAPH_VGA_UFCOUNT_EN)
module saph_vga_pixout
    import saph_vga_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  h_vid_en,
    input  logic                  h_sync_en,
    input  logic                  h_cout,
    input  logic                  v_vid_en,
    input  logic                  v_sync_en,
    input  logic                  v_cout,
    input  logic                  hsync_pol,
    input  logic                  vsync_pol,
    input  logic [PIX_BITS-1:0]   border_col,
    saph_vga_pixout_if.slave      pix,
    output logic                  frame_start,
    output logic [R_MSB-R_LSB:0]  out_r,
    output logic [G_MSB-G_LSB:0]  out_g,
    output logic [B_MSB-B_LSB:0]  out_b,
    output logic                  out_hsync,
    output logic                  out_vsync,
    output logic                  out_de,
    output logic                  underflow,
    input  logic                  underflow_clr
`ifdef SAPH_VGA_UFCOUNT_EN
    ,
    output logic [UF_CNT_W-1:0]   uf_count
`endif
);

    saph_vga_pixout_state_t state_q, state_d;
    saph_vga_rgb565_t       col_q, col_d;
    logic                   frame_start_q, frame_start_d;
    logic                   flush_q, flush_d;
    logic                   underflow_q, underflow_d;

    logic de_in_c;
    logic frame_end_c;
    logic uf_evt_c;

    assign de_in_c     = h_vid_en & v_vid_en;
    assign frame_end_c = inc & h_cout & v_cout;
    // A missing pixel only counts while we are actually streaming
    assign uf_evt_c    = inc & de_in_c & ~pix.pix_valid & (state_q == RUN);

    assign pix.pix_ready = inc & de_in_c & pix.pix_valid & (state_q == RUN);
    assign pix.flush     = flush_q;

    // Next state and registered-output logic
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        frame_start_d = frame_end_c;
        flush_d       = 1'b0;
        underflow_d   = underflow_q;

        unique case (state_q)
            IDLE: if (frame_end_c) state_d = RUN;
            RUN:  if (uf_evt_c) state_d = DROP;
            DROP: begin
                if (frame_end_c) begin
                    state_d = RUN;
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inc) begin
            if (!de_in_c) begin
                col_d = '0;
            end else if ((state_q == RUN) && pix.pix_valid) begin
                col_d = rgb565_unpack(pix.pix_data);
            end else begin
                col_d = rgb565_unpack(border_col);
            end
        end

        // Set has priority over clear
        if (uf_evt_c) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            frame_start_q <= 1'b0;
            flush_q       <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
            flush_q       <= flush_d;
            underflow_q   <= underflow_d;
        end
    end

    assign out_r       = col_q.r;
    assign out_g       = col_q.g;
    assign out_b       = col_q.b;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

`ifdef SAPH_VGA_UFCOUNT_EN
    logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;

    // Saturating event counter; an event coincident with clear leaves a count of one
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (underflow_clr) begin
            uf_cnt_d = UF_CNT_W'(uf_evt_c);
        end else if (uf_evt_c && !(&uf_cnt_q)) begin
            uf_cnt_d = uf_cnt_q + UF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign uf_count = uf_cnt_q;
`endif

    saph_vga_sync_out u_sync_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc),
        .h_sync_en_i (h_sync_en),
        .v_sync_en_i (v_sync_en),
        .de_i        (de_in_c),
        .hsync_pol_i (hsync_pol),
        .vsync_pol_i (vsync_pol),
        .hsync_o     (out_hsync),
        .vsync_o     (out_vsync),
        .de_o        (out_de)
    );

endmodule
